mutex_system: RTL and testbench
===============================

// Module: mutex_system
// PURPOSE
//   Hardware model of the 3-node Murphi mutual-exclusion protocol (node states I/T/C/E plus a shared
//   token bit x). Each clock the environment picks one node via io_en_a; that node fires its single
//   applicable guarded rule. Top-level block for protocol equivalence checking; no submodules.
// PARAMETERS
//   NUM_NODES  3  node count; fixed. io_en_a width and n_reg_* count are sized for exactly 3.
// PORTS
//   clock     in   1  single clock; all state updates on rising edge
//   reset     in   1  asynchronous, active-high reset
//   io_en_a   in   3  rule selector: binary index of the node that fires this cycle
//   io_n_0    out  2  state of node 0 (mirror of n_reg_0)
//   io_n_1    out  2  state of node 1 (mirror of n_reg_1)
//   io_n_2    out  2  state of node 2 (mirror of n_reg_2)
//   io_x      out  1  shared token (mirror of x_reg)
// BEHAVIOUR
//   - State regs: n_reg_0, n_reg_1, n_reg_2 (2b each), x_reg (1b). Outputs are combinational copies.
//   - Encoding: I=2'd0 (idle), T=2'd1 (trying), C=2'd2 (critical), E=2'd3 (exiting).
//   - Reset (async assert, any time, incl. mid-operation): all n_reg_* <= I; x_reg <= 1.
//   - Reset deasserts synchronously to clock; first rule can fire on the first edge with reset=0.
//   - Each edge with reset=0: k = io_en_a. If k in 0..2, node k fires exactly one rule:
//       Try : n[k]==I          -> n[k]<=T
//       Crit: n[k]==T && x==1  -> n[k]<=C, x<=0
//       Exit: n[k]==C          -> n[k]<=E
//       Idle: n[k]==E          -> n[k]<=I, x<=1
//   - Guard false (n[k]==T, x==0): no state change (stall).
//   - k in 3..7: no rule fires; all state holds.
//   - Non-selected nodes never change. One rule at most per cycle, so no simultaneous-update conflicts.
//   - Invariant: at most one node in C or E; x==1 iff no node in C or E. Guaranteed by the rules
//     from the reset state; the block does not re-check it in synthesis.
//   - No handshake; latency 1 cycle from io_en_a to updated outputs.
// CONFIGURATION
//   MUTEX_INVARIANT_CHECK_EN
//     defined  : simulation-only always block checks the invariant every edge with reset=0. On violation
//                it issues $error with cycle count and node states. A sticky internal reg
//                inv_violated (cleared by reset) is set. Ports unchanged.
//     undefined: no check logic or inv_violated reg; RTL is purely the state machine above.
// TESTING
//   1 reset=1 with x_reg=0, n_reg_*=0 preloaded -> after reset: all n=I(0), x=1.
//   2 io_en_a=0 held 4 cycles after reset -> n0: T,C,E,I (1,2,3,0); x: 1,0,0,1; n1=n2=I throughout.
//   3 en=0,0 (n0->C, x=0), then en=1,1,1 -> n1=T then stalls at T; x stays 0.
//   4 From 3, en=0,0 (n0 E->I, x=1), en=1 -> n1=C, x=0.
//   5 io_en_a=3..7 any number of cycles -> all state held unchanged.
//   6 Assert reset while n2=C, x=0 -> immediately (no edge) all n=I, x=1.
//      Random en sequences with MUTEX_INVARIANT_CHECK_EN defined -> no $error.

Source files
------------

// File: rtl/mutex_system.sv
// ============================================================================
// Module   : mutex_system
// Brief    : 3-node Murphi mutual-exclusion protocol; one node fires per clock.
//            Optional invariant monitor: define MUTEX_INVARIANT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mutex_system #(
    parameter int NUM_NODES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] io_en_a,
    output logic [1:0] io_n_0,
    output logic [1:0] io_n_1,
    output logic [1:0] io_n_2,
    output logic       io_x
);

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_T = 2'd1,
        ST_C = 2'd2,
        ST_E = 2'd3
    } node_state_t;

    node_state_t n_reg_0, n_reg_1, n_reg_2;
    logic        x_reg;

    node_state_t w_n_nxt_0, w_n_nxt_1, w_n_nxt_2;
    logic        w_x_nxt;
    node_state_t w_cur, w_new;
    logic        w_new_x;
    logic        w_sel_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_reg_0 <= ST_I;
            n_reg_1 <= ST_I;
            n_reg_2 <= ST_I;
            x_reg   <= 1'b1;
        end else begin
            n_reg_0 <= w_n_nxt_0;
            n_reg_1 <= w_n_nxt_1;
            n_reg_2 <= w_n_nxt_2;
            x_reg   <= w_x_nxt;
        end
    end

    // Evaluate the single applicable rule of the selected node, then write it back.
    always_comb begin
        w_cur       = ST_I;
        w_sel_valid = 1'b1;
        case (io_en_a)
            3'd0:    w_cur = n_reg_0;
            3'd1:    w_cur = n_reg_1;
            3'd2:    w_cur = n_reg_2;
            default: w_sel_valid = 1'b0;
        endcase

        w_new   = w_cur;
        w_new_x = x_reg;
        case (w_cur)
            ST_I: w_new = ST_T;
            ST_T: begin
                if (x_reg) begin
                    w_new   = ST_C;
                    w_new_x = 1'b0;
                end
            end
            ST_C: w_new = ST_E;
            ST_E: begin
                w_new   = ST_I;
                w_new_x = 1'b1;
            end
            default: w_new = w_cur;
        endcase

        w_n_nxt_0 = n_reg_0;
        w_n_nxt_1 = n_reg_1;
        w_n_nxt_2 = n_reg_2;
        w_x_nxt   = x_reg;
        if (w_sel_valid) begin
            w_x_nxt = w_new_x;
            case (io_en_a)
                3'd0:    w_n_nxt_0 = w_new;
                3'd1:    w_n_nxt_1 = w_new;
                default: w_n_nxt_2 = w_new;
            endcase
        end
    end

    assign io_n_0 = n_reg_0;
    assign io_n_1 = n_reg_1;
    assign io_n_2 = n_reg_2;
    assign io_x   = x_reg;

`ifdef MUTEX_INVARIANT_CHECK_EN
    logic        inv_violated;
    logic [31:0] r_cycle_count;
    logic [1:0]  w_crit_count;
    logic        w_inv_bad;

    always_comb begin
        w_crit_count = {1'b0, n_reg_0[1]} + {1'b0, n_reg_1[1]} + {1'b0, n_reg_2[1]};
        w_inv_bad    = (w_crit_count > 2'd1) || (x_reg != (w_crit_count == 2'd0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inv_violated  <= 1'b0;
            r_cycle_count <= 32'd0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_inv_bad) begin
                inv_violated <= 1'b1;
                $error("mutex invariant violated at cycle %0d: n=%0d,%0d,%0d x=%0b",
                       r_cycle_count, n_reg_0, n_reg_1, n_reg_2, x_reg);
            end
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_mutex_system.sv
// ============================================================================
// Module   : tb_mutex_system
// Brief    : Directed and model-checked stimulus for mutex_system.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mutex_system;

    logic       clock;
    logic       reset;
    logic [2:0] io_en_a;
    logic [1:0] io_n_0, io_n_1, io_n_2;
    logic       io_x;

    int checks;
    int passes;

    mutex_system dut (
        .clock   (clock),
        .reset   (reset),
        .io_en_a (io_en_a),
        .io_n_0  (io_n_0),
        .io_n_1  (io_n_1),
        .io_n_2  (io_n_2),
        .io_x    (io_x)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                         input logic [1:0] e2, input logic ex);
        logic [6:0] obs, exp;
        obs = {io_n_0, io_n_1, io_n_2, io_x};
        exp = {e0, e1, e2, ex};
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed n=%0d,%0d,%0d x=%0b expected n=%0d,%0d,%0d x=%0b",
                    tag, io_n_0, io_n_1, io_n_2, io_x, e0, e1, e2, ex);
    endtask

    // Drive selector, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [2:0] en);
        io_en_a = en;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int m_n[3];
        int m_x;
        int k;
        checks  = 0;
        passes  = 0;
        reset   = 1'b1;
        io_en_a = 3'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 2'd0, 2'd0, 2'd0, 1'b1);
        reset = 1'b0;

        // Node 0 full cycle
        step(3'd0); check("n0_try",  2'd1, 2'd0, 2'd0, 1'b1);
        step(3'd0); check("n0_crit", 2'd2, 2'd0, 2'd0, 1'b0);
        step(3'd0); check("n0_exit", 2'd3, 2'd0, 2'd0, 1'b0);
        step(3'd0); check("n0_idle", 2'd0, 2'd0, 2'd0, 1'b1);

        // Node 1 stalls while node 0 holds the token
        step(3'd0); check("n0_try2",   2'd1, 2'd0, 2'd0, 1'b1);
        step(3'd0); check("n0_crit2",  2'd2, 2'd0, 2'd0, 1'b0);
        step(3'd1); check("n1_try",    2'd2, 2'd1, 2'd0, 1'b0);
        step(3'd1); check("n1_stall1", 2'd2, 2'd1, 2'd0, 1'b0);
        step(3'd1); check("n1_stall2", 2'd2, 2'd1, 2'd0, 1'b0);

        // Release token, node 1 enters
        step(3'd0); check("n0_exit2", 2'd3, 2'd1, 2'd0, 1'b0);
        step(3'd0); check("n0_idle2", 2'd0, 2'd1, 2'd0, 1'b1);
        step(3'd1); check("n1_crit",  2'd0, 2'd2, 2'd0, 1'b0);

        // Out-of-range selectors hold all state
        for (int s = 3; s <= 7; s++) begin
            step(s[2:0]);
            check($sformatf("hold_en%0d", s), 2'd0, 2'd2, 2'd0, 1'b0);
        end

        // Move node 2 into critical
        step(3'd1); check("n1_exit", 2'd0, 2'd3, 2'd0, 1'b0);
        step(3'd1); check("n1_idle", 2'd0, 2'd0, 2'd0, 1'b1);
        step(3'd2); check("n2_try",  2'd0, 2'd0, 2'd1, 1'b1);
        step(3'd2); check("n2_crit", 2'd0, 2'd0, 2'd2, 1'b0);

        // Asynchronous reset between edges
        reset = 1'b1;
        #2;
        check("async_reset", 2'd0, 2'd0, 2'd0, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_held", 2'd0, 2'd0, 2'd0, 1'b1);

        // Random selector run against a behavioural reference
        m_n = '{0, 0, 0};
        m_x = 1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 7);
            if (k < 3) begin
                case (m_n[k])
                    0: m_n[k] = 1;
                    1: if (m_x == 1) begin m_n[k] = 2; m_x = 0; end
                    2: m_n[k] = 3;
                    default: begin m_n[k] = 0; m_x = 1; end
                endcase
            end
            step(k[2:0]);
            check($sformatf("rand_%0d_en%0d", i, k), m_n[0][1:0], m_n[1][1:0],
                  m_n[2][1:0], m_x[0]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
